mips32_pipe_ctrl: RTL
=====================

# mips32_pipe_ctrl

Pipeline sequencing controller for the five-stage MIPS32 core (IF, ID, EX, MEM, WB). Each cycle it inspects the ID and EX stage descriptors and drives the stage write-enables, bubble insertion and flush. This covers load-use stalls, taken-branch squash, and the HLT drain-and-stop sequence. It sits beside the datapath, and the datapath's pipeline registers obey its enables.

## Interface
- DRAIN_CYCLES, 3, cycles spent in DRAIN after HLT leaves ID (HLT passes EX, MEM, WB); legal 1–7
- CNT_W, 16, width of the stall counter
- clk1  in  1  single pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  leaves IDLE or HALTED and enters RUN
- id_valid  in  1  ID stage holds a real instruction
- id_type  in  3  ID instruction type: RR=0, RM=1, LOAD=2, STORE=3, BRANCH=4, HLT=7; 5/6 are illegal and treated as NOP
- id_rs, id_rt  in  5 each  ID source register fields
- ex_valid  in  1  EX stage holds a real instruction
- ex_type  in  3  EX instruction type, same encoding
- ex_rd  in  5  EX destination register
- br_taken  in  1  EX branch condition true
- pc_we  out  1  PC update enable
- if_id_we  out  1  IF/ID register load enable
- id_bubble  out  1  load NOP into ID/EX instead of ID contents
- flush  out  1  invalidate IF/ID contents
- halted  out  1  core stopped by HLT (registered)
- state  out  2  IDLE=0, RUN=1, DRAIN=2, HALTED=3 (registered)
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles

## Operation
- **State machine**
  - IDLE: entered on reset. On start go to RUN.
  - RUN: on hlt_det go to DRAIN.
  - DRAIN: counts DRAIN_CYCLES cycles, then goes to HALTED.
  - HALTED: on start go to RUN.
- **Definitions**
  - br_sq = ex_valid & ex_type==BRANCH & br_taken
  - uses_rt = id_type ∈ {RR, STORE, BRANCH}
  - ld_use = ex_valid & ex_type==LOAD & ex_rd!=0 & id_valid & (id_rs==ex_rd | (uses_rt & id_rt==ex_rd))
  - hlt_det = id_valid & id_type==HLT & !br_sq
- **Outputs in RUN** (combinational, Mealy), in priority order:
  1. br_sq: flush=1, id_bubble=1, pc_we=1, if_id_we=1 (the datapath loads the target). A squashed HLT does not halt. Any ld_use in the same cycle is ignored.
  2. ld_use: pc_we=0, if_id_we=0, id_bubble=1, flush=0, and stall_cnt increments.
  3. hlt_det: pc_we=0, if_id_we=0, id_bubble=0 (HLT advances to EX), flush=1.
  4. Otherwise: pc_we=1, if_id_we=1, id_bubble=0, flush=0.
- **Outputs in DRAIN:** pc_we=0, if_id_we=0, id_bubble=1, flush=1. br_taken is ignored, because no older branch can remain.
- **Outputs in IDLE and HALTED:** pc_we=0, if_id_we=0, id_bubble=1, flush=1.
  - Exception: in the start cycle, outputs follow RUN rules with id_valid forced to 0.
- **halted:** 1 exactly while state==HALTED.
- **stall_cnt:**
  - Saturates at all-ones.
  - Cleared only by rst.
  - Not cleared by start.
- **Drain counter:** 3 bits. Loaded with DRAIN_CYCLES-1 on RUN→DRAIN and decremented each DRAIN cycle. The DRAIN→HALTED transition happens on the cycle where it reads 0.
- Register 0 is never a hazard source.
- Illegal id_type 5 or 6 produces no hazard and no halt. Its id_rs is still compared for ld_use.

## Timing
- rst asserted at any time gives, immediately and asynchronously: state=IDLE, halted=0, stall_cnt=0, drain counter=0. Combinational outputs then settle to IDLE values: pc_we=0, if_id_we=0, id_bubble=1, flush=1.
- Reset in mid-DRAIN or mid-stall discards all progress.
- Load-use stall lasts exactly 1 cycle per hazard. The next cycle, the LOAD is in MEM and ld_use drops unless a new LOAD has reached EX.
- Branch squash is a 1-cycle pulse on flush and id_bubble.
- HLT sequence:
  - The HLT detection cycle is T.
  - Cycles T+1 … T+DRAIN_CYCLES are in DRAIN.
  - halted=1 from T+DRAIN_CYCLES+1.
- start in HALTED: state=RUN the next cycle and pc_we=1 in that cycle (absent hazards).
- start while in RUN or DRAIN is ignored.

## Test plan
- **Load-use via rs:** ex_type=LOAD, ex_rd=5, id_type=RR, id_rs=5, both valid → one cycle of pc_we=0, if_id_we=0, id_bubble=1; stall_cnt 0→1. With ex_rd=0 the same stimulus gives no stall.
- **rt hazard per type:** id_rt=7=ex_rd (LOAD in EX) → stall for id_type RR, STORE and BRANCH; no stall for RM and LOAD.
- **Branch beats stall and halt:** br_sq=1 together with ld_use=1 and an HLT in ID → flush=1, id_bubble=1, pc_we=1, stall_cnt unchanged, state stays RUN.
- **HLT drain:** HLT reaches ID at cycle 10 in RUN → state=DRAIN at 11–13, halted=1 and state=3 at 14, pc_we=0 from cycle 10 onward. Pulse start at 20 → state=RUN at 21.
- **Reset mid-DRAIN:** assert rst at cycle 12 between clock edges → state=0 and flush=1 immediately. After release, outputs stay at IDLE values until start.
- **Counter saturation:** CNT_W=4 with 20 back-to-back load-use hazards → stall_cnt holds at 15.

Source files
------------

// File: rtl/mips32_pipe_ctrl_if.sv
// Pipeline-control bundle between the MIPS32 datapath and its sequencing controller.
// The datapath (master) presents ID/EX stage descriptors and obeys the enables;
// the controller (slave) consumes the descriptors and drives the enables.
interface mips32_pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             id_valid;
    logic [2:0]       id_type;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_valid;
    logic [2:0]       ex_type;
    logic [4:0]       ex_rd;
    logic             br_taken;

    logic             pc_we;
    logic             if_id_we;
    logic             id_bubble;
    logic             flush;
    logic             halted;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output start, id_valid, id_type, id_rs, id_rt,
               ex_valid, ex_type, ex_rd, br_taken,
        input  pc_we, if_id_we, id_bubble, flush, halted, state, stall_cnt
    );

    modport slave (
        input  start, id_valid, id_type, id_rs, id_rt,
               ex_valid, ex_type, ex_rd, br_taken,
        output pc_we, if_id_we, id_bubble, flush, halted, state, stall_cnt
    );
endinterface

// File: rtl/mips32_pipe_ctrl.sv
// Five-stage MIPS32 pipeline sequencing: load-use stall, taken-branch squash,
// and HLT drain-and-stop.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | after reset; pipeline frozen until start
//   RUN     | normal issue; hazards resolved by stall / squash
//   DRAIN   | HLT left ID; older instructions retire for DRAIN_CYCLES cycles
//   HALTED  | core stopped by HLT; start resumes issue
module mips32_pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk1,
    input  logic              rst,
    mips32_pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [2:0] T_RR     = 3'd0;
    localparam logic [2:0] T_LOAD   = 3'd2;
    localparam logic [2:0] T_STORE  = 3'd3;
    localparam logic [2:0] T_BRANCH = 3'd4;
    localparam logic [2:0] T_HLT    = 3'd7;

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       drain_q;
    logic             halted_q;
    logic [CNT_W-1:0] stall_q;

    logic run_rules;
    logic id_v;
    logic uses_rt;
    logic br_sq;
    logic ld_use;
    logic hlt_det;
    logic stall_inc;

    // The start cycle out of IDLE/HALTED applies RUN rules with ID treated as empty,
    // so whatever sits in IF/ID from before the stop can never stall or halt.
    assign run_rules = (state_q == RUN) |
                       (((state_q == IDLE) | (state_q == HALTED)) & bus.start);
    assign id_v      = bus.id_valid & (state_q == RUN);

    assign uses_rt = (bus.id_type == T_RR) | (bus.id_type == T_STORE) |
                     (bus.id_type == T_BRANCH);
    assign br_sq   = bus.ex_valid & (bus.ex_type == T_BRANCH) & bus.br_taken;
    assign ld_use  = bus.ex_valid & (bus.ex_type == T_LOAD) & (bus.ex_rd != 5'd0) & id_v &
                     ((bus.id_rs == bus.ex_rd) | (uses_rt & (bus.id_rt == bus.ex_rd)));
    assign hlt_det = id_v & (bus.id_type == T_HLT) & ~br_sq;

    // State, drain counter and halted flag registers
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            drain_q  <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALTED);
            if (state_q == RUN && state_d == DRAIN)
                drain_q <= DRAIN_LOAD;
            else if (state_q == DRAIN && drain_q != 3'd0)
                drain_q <= drain_q - 3'd1;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start)         state_d = RUN;
            RUN:     if (hlt_det)           state_d = DRAIN;
            DRAIN:   if (drain_q == 3'd0)   state_d = HALTED;
            HALTED:  if (bus.start)         state_d = RUN;
            default:                        state_d = IDLE;
        endcase
    end

    // Stage enables; branch squash outranks load-use stall, which outranks HLT
    always_comb begin
        bus.pc_we     = 1'b0;
        bus.if_id_we  = 1'b0;
        bus.id_bubble = 1'b1;
        bus.flush     = 1'b1;
        stall_inc     = 1'b0;
        if (run_rules) begin
            if (br_sq) begin
                bus.pc_we     = 1'b1;
                bus.if_id_we  = 1'b1;
                bus.id_bubble = 1'b1;
                bus.flush     = 1'b1;
            end else if (ld_use) begin
                bus.pc_we     = 1'b0;
                bus.if_id_we  = 1'b0;
                bus.id_bubble = 1'b1;
                bus.flush     = 1'b0;
                stall_inc     = 1'b1;
            end else if (hlt_det) begin
                bus.pc_we     = 1'b0;
                bus.if_id_we  = 1'b0;
                bus.id_bubble = 1'b0;
                bus.flush     = 1'b1;
            end else begin
                bus.pc_we     = 1'b1;
                bus.if_id_we  = 1'b1;
                bus.id_bubble = 1'b0;
                bus.flush     = 1'b0;
            end
        end
    end

    // Saturating load-use stall counter, survives start
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (stall_inc && stall_q != {CNT_W{1'b1}})
            stall_q <= stall_q + CNT_W'(1);
    end

    assign bus.state     = state_q;
    assign bus.halted    = halted_q;
    assign bus.stall_cnt = stall_q;

endmodule
